// File: rtl/pic8259a_pkg.sv
// rtl/pic8259a_pkg.sv - shared types and constants for the 8259A acknowledge initiator
package pic8259a_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE_LOW,
    PULSE_HIGH,
    DONE
  } inta_state_e;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [1:0] PULSES_8086 = 2'd2;
  localparam logic [1:0] PULSES_8080 = 2'd3;

  function automatic logic [1:0] final_pulse_index(input logic is_8086);
    return is_8086 ? (PULSES_8086 - 2'd1) : (PULSES_8080 - 2'd1);
  endfunction

endpackage

// File: rtl/inta_phase_timer.sv
// rtl/inta_phase_timer.sv - loadable down-counter timing one INTA_N phase
module inta_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // Flags the final cycle of a phase so the FSM can switch on the closing edge.
  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/pic_inta_initiator.sv
// rtl/pic_inta_initiator.sv - INTA_N pulse-train generator with vector/CALL capture
module pic_inta_initiator
  import pic8259a_pkg::*;
#(
  parameter int INTA_LOW_CYCLES  = 2,
  parameter int INTA_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_enable,
  input  logic        mode_8086,
  input  logic        interrupt_request,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic        vector_valid,
  output logic [7:0]  vector,
  output logic [15:0] call_address,
  output logic        opcode_error,
  input  logic        vector_taken
);

  localparam int PHASE_MAX = (INTA_LOW_CYCLES > INTA_HIGH_CYCLES) ? INTA_LOW_CYCLES : INTA_HIGH_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam logic [PHASE_W-1:0] LOW_LOAD  = PHASE_W'(INTA_LOW_CYCLES);
  localparam logic [PHASE_W-1:0] HIGH_LOAD = PHASE_W'(INTA_HIGH_CYCLES);

  inta_state_e        state;
  logic               start_pending;
  logic               mode_latched;
  logic [1:0]         pulse_index;
  logic               last_pulse;
  logic               timer_start;
  logic [PHASE_W-1:0] timer_load;
  logic               phase_expire;

  assign last_pulse = (pulse_index == final_pulse_index(mode_latched));

  always_comb begin
    timer_start = 1'b0;
    timer_load  = LOW_LOAD;
    case (state)
      IDLE:       timer_start = start_pending;
      PULSE_LOW:  begin
        timer_start = phase_expire && !last_pulse;
        timer_load  = HIGH_LOAD;
      end
      PULSE_HIGH: timer_start = phase_expire;
      default:    timer_start = 1'b0;
    endcase
  end

  inta_phase_timer #(.WIDTH(PHASE_W)) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .start      (timer_start),
    .load_value (timer_load),
    .expire     (phase_expire)
  );

  // The acceptance edge only arms the sequence; INTA_N first falls one edge later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      start_pending           <= 1'b0;
      mode_latched            <= 1'b0;
      pulse_index             <= 2'd0;
      interrupt_acknowledge_n <= 1'b1;
      busy                    <= 1'b0;
      vector_valid            <= 1'b0;
      vector                  <= 8'h00;
      call_address            <= 16'h0000;
      opcode_error            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pending) begin
            start_pending           <= 1'b0;
            state                   <= PULSE_LOW;
            interrupt_acknowledge_n <= 1'b0;
            busy                    <= 1'b1;
          end else if (interrupt_request && interrupt_enable) begin
            start_pending <= 1'b1;
            mode_latched  <= mode_8086;
            pulse_index   <= 2'd0;
            vector        <= 8'h00;
            call_address  <= 16'h0000;
            opcode_error  <= 1'b0;
          end
        end
        PULSE_LOW: begin
          if (phase_expire) begin
            interrupt_acknowledge_n <= 1'b1;
            if (mode_latched) begin
              if (pulse_index == 2'd1) vector <= data_bus_in;
            end else begin
              case (pulse_index)
                2'd0:    opcode_error       <= (data_bus_in != CALL_OPCODE);
                2'd1:    call_address[7:0]  <= data_bus_in;
                2'd2:    call_address[15:8] <= data_bus_in;
                default: opcode_error       <= opcode_error;
              endcase
            end
            if (last_pulse) begin
              state        <= DONE;
              vector_valid <= 1'b1;
            end else begin
              state       <= PULSE_HIGH;
              pulse_index <= pulse_index + 2'd1;
            end
          end
        end
        PULSE_HIGH: begin
          if (phase_expire) begin
            state                   <= PULSE_LOW;
            interrupt_acknowledge_n <= 1'b0;
          end
        end
        DONE: begin
          if (vector_taken) begin
            state        <= IDLE;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_inta_initiator.sv
// tb/tb_pic_inta_initiator.sv - self-checking bench for pic_inta_initiator
module tb_pic_inta_initiator;

  localparam int LS[3] = '{2, 1, 5};
  localparam int HS[3] = '{2, 1, 3};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ie = 1'b0;
  logic        mode = 1'b1;
  logic [7:0]  data_bus = 8'h00;
  logic        taken = 1'b0;
  logic        req[3];
  logic        inta_n[3];
  logic        busy[3];
  logic        valid[3];
  logic [7:0]  vector[3];
  logic [15:0] call_address[3];
  logic        opcode_error[3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         idx;
    logic       mode;
    logic [7:0] b0, b1, b2;
    logic [7:0] ev;
    logic [15:0] ec;
    logic       eo;
    bit         drop;
    bit         flip;
  } vec_t;

  typedef struct {
    logic [7:0]  vec;
    logic [15:0] call;
    logic        oe;
    int          vcyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pic_inta_initiator #(
      .INTA_LOW_CYCLES  (LS[g]),
      .INTA_HIGH_CYCLES (HS[g])
    ) u_dut (
      .clock                   (clock),
      .reset                   (reset),
      .interrupt_enable        (ie),
      .mode_8086               (mode),
      .interrupt_request       (req[g]),
      .data_bus_in             (data_bus),
      .interrupt_acknowledge_n (inta_n[g]),
      .busy                    (busy[g]),
      .vector_valid            (valid[g]),
      .vector                  (vector[g]),
      .call_address            (call_address[g]),
      .opcode_error            (opcode_error[g]),
      .vector_taken            (taken)
    );
  end

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    taken = 1'b0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_seq(input int idx, input logic m, input logic [7:0] b0, b1, b2,
                         input logic [7:0] ev, input logic [15:0] ec, input logic eo,
                         input bit drop, input bit flip, input bit keep, input bit take);
    logic [7:0] pb[3];
    int l, h, np, start, rel, pulses, vcyc, wave_err, busy_err;
    logic prev, expl, got;
    exp_t e;
    l = LS[idx];
    h = HS[idx];
    np = m ? 2 : 3;
    pb[0] = b0; pb[1] = b1; pb[2] = b2;
    pulses = 0; prev = 1'b1; got = 1'b0; vcyc = -1; wave_err = 0; busy_err = 0;
    @(negedge clock);
    mode = m;
    ie = 1'b1;
    req[idx] = 1'b1;
    start = cyc + 1;
    sb.push_back('{ev, ec, eo, np * l + (np - 1) * h + 1});
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clock);
      rel = cyc - start;
      expl = 1'b0;
      for (int p = 0; p < np; p++)
        if (rel >= 1 + p * (l + h) && rel <= p * (l + h) + l) expl = 1'b1;
      if (inta_n[idx] !== !expl) wave_err++;
      if (busy[idx] !== (rel >= 1)) busy_err++;
      if (inta_n[idx] === 1'b0 && prev === 1'b1) begin
        pulses++;
        if (pulses <= 3) data_bus = pb[pulses-1];
      end
      prev = inta_n[idx];
      if (drop && pulses == 1 && inta_n[idx] === 1'b1) req[idx] = 1'b0;
      if (flip && pulses == 1) mode = ~m;
      if (valid[idx] === 1'b1) begin
        got = 1'b1;
        vcyc = rel;
      end
    end
    mode = m;
    e = sb.pop_front();
    chk($sformatf("inta_wave[%0d]", idx), wave_err, 0);
    chk($sformatf("busy_wave[%0d]", idx), busy_err, 0);
    chk($sformatf("valid_cycle[%0d]", idx), vcyc, e.vcyc);
    chk($sformatf("vector[%0d]", idx), vector[idx], e.vec);
    chk($sformatf("call_address[%0d]", idx), call_address[idx], e.call);
    chk($sformatf("opcode_error[%0d]", idx), opcode_error[idx], e.oe);
    if (!keep) req[idx] = 1'b0;
    if (take) begin
      taken = 1'b1;
      @(negedge clock);
      taken = 1'b0;
      chk($sformatf("valid_after_take[%0d]", idx), valid[idx], 1'b0);
      chk($sformatf("busy_after_take[%0d]", idx), busy[idx], 1'b0);
    end
  endtask

  initial begin
    int err_cnt, pulses;
    logic prev, hit;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;

    tbl[0] = '{0, 1'b1, 8'h00, 8'h4A, 8'h00, 8'h4A, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{0, 1'b0, 8'hCD, 8'h3C, 8'h12, 8'h00, 16'h123C, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{0, 1'b0, 8'hC3, 8'h3C, 8'h12, 8'h00, 16'h123C, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{0, 1'b1, 8'h00, 8'h4F, 8'h00, 8'h4F, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1, 1'b1, 8'h11, 8'h5A, 8'h00, 8'h5A, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1, 1'b0, 8'hCD, 8'h34, 8'h12, 8'h00, 16'h1234, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{2, 1'b1, 8'h00, 8'hA5, 8'h00, 8'hA5, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{2, 1'b0, 8'hCD, 8'hEF, 8'hBE, 8'h00, 16'hBEEF, 1'b0, 1'b0, 1'b1};

    @(negedge clock);
    chk("reset_inta_n", inta_n[0], 1'b1);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_valid", valid[0], 1'b0);
    chk("reset_vector", vector[0], 8'h00);
    chk("reset_call", call_address[0], 16'h0000);
    chk("reset_opcode_error", opcode_error[0], 1'b0);
    @(negedge clock);
    reset = 1'b0;

    for (int t = 0; t < 8; t++)
      run_seq(tbl[t].idx, tbl[t].mode, tbl[t].b0, tbl[t].b1, tbl[t].b2,
              tbl[t].ev, tbl[t].ec, tbl[t].eo, tbl[t].drop, tbl[t].flip, 1'b0, 1'b1);

    // Interrupt enable low: no acknowledge even with INT asserted.
    do_reset();
    @(negedge clock);
    ie = 1'b0;
    req[0] = 1'b1;
    err_cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (inta_n[0] !== 1'b1 || busy[0] !== 1'b0) err_cnt++;
    end
    chk("gated_idle", err_cnt, 0);
    req[0] = 1'b0;

    // Backpressure in DONE with INT still high, then restart timing.
    run_seq(0, 1'b1, 8'h00, 8'h4A, 8'h00, 8'h4A, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    err_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (inta_n[0] !== 1'b1 || valid[0] !== 1'b1 || busy[0] !== 1'b1 || vector[0] !== 8'h4A) err_cnt++;
    end
    chk("backpressure_stable", err_cnt, 0);
    taken = 1'b1;
    @(negedge clock);
    taken = 1'b0;
    chk("bp_valid_drop", valid[0], 1'b0);
    chk("bp_inta_t0", inta_n[0], 1'b1);
    @(negedge clock);
    chk("bp_inta_t1", inta_n[0], 1'b1);
    @(negedge clock);
    chk("bp_inta_t2", inta_n[0], 1'b0);
    do_reset();

    // Asynchronous reset while holding a result in DONE.
    run_seq(0, 1'b0, 8'hC3, 8'h3C, 8'h12, 8'h00, 16'h123C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("done_reset_valid", valid[0], 1'b0);
    chk("done_reset_call", call_address[0], 16'h0000);
    chk("done_reset_opcode_error", opcode_error[0], 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset during the second low pulse.
    @(negedge clock);
    mode = 1'b1;
    ie = 1'b1;
    req[0] = 1'b1;
    pulses = 0;
    prev = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clock);
      if (inta_n[0] === 1'b0 && prev === 1'b1) pulses++;
      prev = inta_n[0];
      if (pulses == 2 && inta_n[0] === 1'b0) hit = 1'b1;
    end
    chk("pulse2_reached", hit, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midpulse_inta_n", inta_n[0], 1'b1);
    chk("midpulse_busy", busy[0], 1'b0);
    chk("midpulse_valid", valid[0], 1'b0);
    chk("midpulse_vector", vector[0], 8'h00);
    @(negedge clock);
    req[0] = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
